// File: rtl/reg_univ.sv
// reg_univ -- universal register: load, shift, rotate, synchronous preset/clear,
// asynchronous active-low reset, sticky preset/clear conflict flag.
// The active clock edge is chosen by parameter NEGEDGE.
// Optional up/down counting (modes 110/111) and terminal count are built only
// when macro REG_UNIV_CNT_EN is defined; otherwise modes 110/111 hold and tc = 0.
module reg_univ #(
    parameter int                 WIDTH      = 8,
    parameter int                 NEGEDGE    = 1,
    parameter logic [WIDTH-1:0]   PRESET_VAL = {WIDTH{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              preset,
    input  logic              clear,
    input  logic              en,
    input  logic [2:0]        mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              sin_l,
    input  logic              sin_r,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  q_n,
    output logic              sout_l,
    output logic              sout_r,
    output logic              conflict,
    output logic              tc
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
`ifdef REG_UNIV_CNT_EN
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
`endif

    logic [WIDTH-1:0] q_nxt;
    logic             conflict_nxt;

    function automatic logic [WIDTH-1:0] rot_left(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] rot_right(input logic [WIDTH-1:0] v);
        return {v[0], v[WIDTH-1:1]};
    endfunction

    // Next-state selection: clear beats preset beats hold (en=0) beats mode decode.
    always_comb begin
        q_nxt        = q;
        conflict_nxt = conflict;
        if (clear) begin
            q_nxt = ZERO;
            if (preset) begin
                conflict_nxt = 1'b1;
            end else begin
                conflict_nxt = conflict;
            end
        end else if (preset) begin
            q_nxt = PRESET_VAL;
        end else if (!en) begin
            q_nxt = q;
        end else begin
            // Unknown or unlisted mode values fall through to default and hold.
            case (mode)
                3'b000:  q_nxt = q;
                3'b001:  q_nxt = d;
                3'b010:  q_nxt = {q[WIDTH-2:0], sin_l};
                3'b011:  q_nxt = {sin_r, q[WIDTH-1:1]};
                3'b100:  q_nxt = rot_left(q);
                3'b101:  q_nxt = rot_right(q);
`ifdef REG_UNIV_CNT_EN
                3'b110:  q_nxt = q + ONE;
                3'b111:  q_nxt = q - ONE;
`endif
                default: q_nxt = q;
            endcase
        end
    end

    generate
        if (NEGEDGE != 0) begin : g_fall
            // State register updated on the falling clock edge, reset asynchronously.
            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q        <= ZERO;
                    conflict <= 1'b0;
                end else begin
                    q        <= q_nxt;
                    conflict <= conflict_nxt;
                end
            end
        end else begin : g_rise
            // State register updated on the rising clock edge, reset asynchronously.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q        <= ZERO;
                    conflict <= 1'b0;
                end else begin
                    q        <= q_nxt;
                    conflict <= conflict_nxt;
                end
            end
        end
    endgenerate

    assign q_n    = ~q;
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];

`ifdef REG_UNIV_CNT_EN
    // Terminal count flags the edge on which the counter is about to wrap.
    assign tc = en & ~preset & ~clear &
                (((mode == 3'b110) & (q == ONES)) | ((mode == 3'b111) & (q == ZERO)));
`else
    assign tc = 1'b0;
`endif

endmodule

// File: tb/tb_reg_univ.sv
// Directed-vector bench for reg_univ with a queue-based scoreboard.
// dut0: WIDTH=8, NEGEDGE=1, PRESET_VAL=8'hFF. dut1: NEGEDGE=0, PRESET_VAL=8'h3C.
// Expectations for modes 110/111 follow REG_UNIV_CNT_EN.
module tb_reg_univ;

`ifdef REG_UNIV_CNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       preset, clear, en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_l, sin_r;
    logic [7:0] q0, q_n0;
    logic       sout_l0, sout_r0, conflict0, tc0;

    logic       preset1;
    logic [7:0] q1, q_n1;
    logic       sout_l1, sout_r1, conflict1, tc1;

    reg_univ #(.WIDTH(8), .NEGEDGE(1), .PRESET_VAL(8'hFF)) dut0 (
        .clk(clk), .rst_n(rst_n), .preset(preset), .clear(clear), .en(en),
        .mode(mode), .d(d), .sin_l(sin_l), .sin_r(sin_r),
        .q(q0), .q_n(q_n0), .sout_l(sout_l0), .sout_r(sout_r0),
        .conflict(conflict0), .tc(tc0)
    );

    reg_univ #(.WIDTH(8), .NEGEDGE(0), .PRESET_VAL(8'h3C)) dut1 (
        .clk(clk), .rst_n(rst_n), .preset(preset1), .clear(1'b0), .en(1'b0),
        .mode(3'b000), .d(8'h00), .sin_l(1'b0), .sin_r(1'b0),
        .q(q1), .q_n(q_n1), .sout_l(sout_l1), .sout_r(sout_r1),
        .conflict(conflict1), .tc(tc1)
    );

    typedef struct {
        string      name;
        bit         which;
        logic [7:0] q;
        logic       conf;
        logic       tc;
    } item_t;

    item_t pre_q[$];
    item_t post_q[$];

    int tests = 0;
    int fails = 0;

    logic [7:0] cur_q, cur_q1;
    logic       cur_conf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic tc_f(input logic [7:0] qv, input logic e, input logic p,
                                  input logic c, input logic [2:0] m);
        return CNT & e & ~p & ~c &
               (((m == 3'b110) && (qv == 8'hFF)) || ((m == 3'b111) && (qv == 8'h00)));
    endfunction

    task automatic cmp(input string nm, input string fld, input logic [7:0] act,
                       input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %h, expected %h", nm, fld, act, exp);
        end
    endtask

    task automatic check(input item_t it);
        if (it.which == 1'b0) begin
            cmp(it.name, "q",        q0,                   it.q);
            cmp(it.name, "q_n",      q_n0,                 ~it.q);
            cmp(it.name, "sout_l",   {7'd0, sout_l0},      {7'd0, it.q[7]});
            cmp(it.name, "sout_r",   {7'd0, sout_r0},      {7'd0, it.q[0]});
            cmp(it.name, "conflict", {7'd0, conflict0},    {7'd0, it.conf});
            cmp(it.name, "tc",       {7'd0, tc0},          {7'd0, it.tc});
        end else begin
            cmp(it.name, "q1",        q1,                  it.q);
            cmp(it.name, "q_n1",      q_n1,                ~it.q);
            cmp(it.name, "sout_l1",   {7'd0, sout_l1},     {7'd0, it.q[7]});
            cmp(it.name, "sout_r1",   {7'd0, sout_r1},     {7'd0, it.q[0]});
            cmp(it.name, "conflict1", {7'd0, conflict1},   {7'd0, it.conf});
            cmp(it.name, "tc1",       {7'd0, tc1},         {7'd0, it.tc});
        end
    endtask

    // Monitor: pre-edge expectations sampled before the falling edge,
    // post-edge expectations sampled after it (and before the next rising edge).
    initial begin
        item_t it;
        forever begin
            @(posedge clk);
            #3;
            while (pre_q.size() > 0) begin
                it = pre_q.pop_front();
                check(it);
            end
            @(negedge clk);
            #3;
            while (post_q.size() > 0) begin
                it = post_q.pop_front();
                check(it);
            end
        end
    end

    // One stimulus cycle: drive just after the rising edge, push expectations.
    task automatic cyc(input string nm, input logic rn, input logic p, input logic c,
                       input logic e, input logic [2:0] m, input logic [7:0] dd,
                       input logic sl, input logic sr, input logic p1,
                       input logic [7:0] qp, input logic cp);
        item_t it;
        @(posedge clk);
        #1;
        rst_n = rn; preset = p; clear = c; en = e; mode = m; d = dd;
        sin_l = sl; sin_r = sr; preset1 = p1;

        it.name  = {nm, "/pre"};
        it.which = 1'b0;
        it.q     = rn ? cur_q : 8'h00;
        it.conf  = rn ? cur_conf : 1'b0;
        it.tc    = tc_f(it.q, e, p, c, m);
        pre_q.push_back(it);
        it.which = 1'b1;
        it.q     = rn ? cur_q1 : 8'h00;
        it.conf  = 1'b0;
        it.tc    = 1'b0;
        pre_q.push_back(it);

        it.name  = {nm, "/post"};
        it.which = 1'b0;
        it.q     = qp;
        it.conf  = cp;
        it.tc    = tc_f(qp, e, p, c, m);
        post_q.push_back(it);
        it.which = 1'b1;
        it.q     = rn ? cur_q1 : 8'h00;
        it.conf  = 1'b0;
        it.tc    = 1'b0;
        post_q.push_back(it);

        cur_q    = qp;
        cur_conf = cp;
        cur_q1   = !rn ? 8'h00 : (p1 ? 8'h3C : cur_q1);
    endtask

    initial begin
        rst_n = 1'b0; preset = 1'b0; clear = 1'b0; en = 1'b0; mode = 3'b000;
        d = 8'h00; sin_l = 1'b0; sin_r = 1'b0; preset1 = 1'b0;
        cur_q = 8'h00; cur_q1 = 8'h00; cur_conf = 1'b0;

        //   name            rn    p     c     e     mode    d      sl    sr    p1    q_post              conf
        cyc("reset",        1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00,              1'b0);
        cyc("load_a5",      1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5,              1'b0);
        cyc("shl",          1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 1'b0, 8'h4B,              1'b0);
        cyc("shr",          1'b1, 1'b0, 1'b0, 1'b1, 3'b011, 8'h00, 1'b1, 1'b0, 1'b0, 8'h25,              1'b0);
        cyc("en0_shl",      1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h25,              1'b0);
        cyc("en0_load",     1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h25,              1'b0);
        cyc("load_81a",     1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81,              1'b0);
        cyc("rotl",         1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 1'b0, 8'h03,              1'b0);
        cyc("load_81b",     1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81,              1'b0);
        cyc("rotr",         1'b1, 1'b0, 1'b0, 1'b1, 3'b101, 8'h00, 1'b1, 1'b1, 1'b0, 8'hC0,              1'b0);
        cyc("mode_hold",    1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 8'h77, 1'b1, 1'b1, 1'b0, 8'hC0,              1'b0);
        cyc("load_fe",      1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 8'hFE, 1'b0, 1'b0, 1'b0, 8'hFE,              1'b0);
        cyc("inc1",         1'b1, 1'b0, 1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 1'b0, CNT ? 8'hFF : 8'hFE, 1'b0);
        cyc("inc2",         1'b1, 1'b0, 1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 1'b0, CNT ? 8'h00 : 8'hFE, 1'b0);
        cyc("load_00",      1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00,              1'b0);
        cyc("dec",          1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 1'b0, CNT ? 8'hFF : 8'h00, 1'b0);
        cyc("inc_preset",   1'b1, 1'b1, 1'b0, 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF,              1'b0);
        cyc("load_12",      1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 8'h12, 1'b0, 1'b0, 1'b0, 8'h12,              1'b0);
        cyc("preset_en0",   1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 8'h00, 1'b0, 1'b0, 1'b0, 8'hFF,              1'b0);
        cyc("conflict",     1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 8'h66, 1'b0, 1'b0, 1'b0, 8'h00,              1'b1);
        cyc("conf_sticky",  1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A,              1'b1);
        cyc("clear",        1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 8'h33, 1'b0, 1'b0, 1'b0, 8'h00,              1'b1);
        cyc("load_5a",      1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A,              1'b1);
        cyc("async_rst",    1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00,              1'b0);
        cyc("post_rst_shl", 1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 1'b0, 8'h01,              1'b0);

        @(posedge clk);
        @(negedge clk);
        #5;
        tests++;
        if ((pre_q.size() != 0) || (post_q.size() != 0)) begin
            fails++;
            $display("FAIL drain: %0d/%0d items left, expected 0/0", pre_q.size(), post_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
